// File: rtl/tl_rr_scheduler.sv
// Bounded-burst round-robin scheduler draining four input VC FIFOs into matching output FIFOs.
// Define TL_SCHED_STRICT_PRIO_EN to pick the lowest-index eligible input at each burst boundary.
module tl_rr_scheduler #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic [3:0] empty_in,
  input  logic [3:0] alm_full_out,
  output logic [3:0] pop,
  output logic       push,
  output logic [1:0] route_sel,
  output logic [1:0] grant_idx,
  output logic       busy,
  output logic       all_idle
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [0:0] state_reg, state_next;
  logic [1:0] rr_ptr_reg, rr_ptr_next;
  logic [1:0] grant_reg, grant_next;
  logic [3:0] burst_cnt_reg, burst_cnt_next;
  logic       push_reg;
  logic [1:0] route_sel_reg;

  logic [3:0] eligible;
  logic [1:0] search_base;
  logic [1:0] sel_idx;
  logic       grant_ok;
  logic       pop_fire;
  logic       burst_exit;

  assign eligible = ~empty_in & ~alm_full_out;

`ifdef TL_SCHED_STRICT_PRIO_EN
  assign search_base = 2'd0;
`else
  assign search_base = rr_ptr_reg;
`endif

  // Walk offsets from farthest to nearest so the nearest eligible input wins.
  always_comb begin
    sel_idx = search_base;
    for (int k = 3; k >= 0; k--) begin
      if (eligible[search_base + 2'(k)]) sel_idx = search_base + 2'(k);
    end
  end

  assign grant_ok = eligible[grant_reg] & active & ~reset;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pop
      assign pop[gi] = (state_reg == ST_BURST) && (grant_reg == 2'(gi)) && grant_ok;
    end
  endgenerate

  assign pop_fire   = |pop;
  assign burst_exit = (pop_fire && (burst_cnt_reg == BURST_LAST)) ||
                      !eligible[grant_reg] || !active;

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_next     = grant_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (active && |eligible) begin
          state_next     = ST_BURST;
          grant_next     = sel_idx;
          burst_cnt_next = 4'd0;
        end
      end
      default: begin
        if (burst_exit) begin
          state_next     = ST_IDLE;
          rr_ptr_next    = grant_reg + 2'd1;
          burst_cnt_next = 4'd0;
        end else if (pop_fire) begin
          burst_cnt_next = burst_cnt_reg + 4'd1;
        end
      end
    endcase
  end

  // Push trails pop by one cycle to match the input FIFO read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= 2'd0;
      grant_reg     <= 2'd0;
      burst_cnt_reg <= 4'd0;
      push_reg      <= 1'b0;
      route_sel_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_reg     <= grant_next;
      burst_cnt_reg <= burst_cnt_next;
      push_reg      <= pop_fire;
      route_sel_reg <= grant_reg;
    end
  end

  assign push      = push_reg;
  assign route_sel = route_sel_reg;
  assign grant_idx = grant_reg;
  assign busy      = (state_reg == ST_BURST);
  assign all_idle  = &empty_in & ~push_reg;

endmodule

// File: tb/tb_tl_rr_scheduler.sv
// Directed self-checking bench for tl_rr_scheduler (MAX_BURST = 4) with word-counting FIFO models.
module tb_tl_rr_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       active = 1'b0;
  logic [3:0] empty_in;
  logic [3:0] alm_full_out = 4'b0000;
  logic [3:0] pop;
  logic       push;
  logic [1:0] route_sel;
  logic [1:0] grant_idx;
  logic       busy;
  logic       all_idle;

  int fill   [4] = '{default: 0};
  int popped [4] = '{default: 0};
  int n_checks = 0;
  int n_fail   = 0;

  tl_rr_scheduler #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .active(active), .empty_in(empty_in),
    .alm_full_out(alm_full_out), .pop(pop), .push(push), .route_sel(route_sel),
    .grant_idx(grant_idx), .busy(busy), .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  // Input FIFO model: word count = fill - popped.
  always_comb begin
    empty_in = 4'b0000;
    for (int i = 0; i < 4; i++) empty_in[i] = (fill[i] == popped[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (pop[i]) popped[i] <= popped[i] + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load(input int i, input int n);
    fill[i] = popped[i] + n;
  endtask

  task automatic start_clean();
    reset = 1'b1;
    active = 1'b0;
    alm_full_out = 4'b0000;
    for (int i = 0; i < 4; i++) fill[i] = popped[i];
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    active = 1'b1;
    for (int i = 0; i < 4; i++) load(i, 2);
    tick();
    tick();
    n_checks++;
    if (pop !== 4'b0000) begin n_fail++; $display("FAIL reset_pop: got %b want 0000", pop); end
    n_checks++;
    if ({push, route_sel, grant_idx, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_regs: push=%b route_sel=%0d grant_idx=%0d busy=%b want all 0",
               push, route_sel, grant_idx, busy);
    end
    for (int i = 0; i < 4; i++) fill[i] = popped[i];
    settle();
    n_checks++;
    if (all_idle !== 1'b1) begin n_fail++; $display("FAIL reset_all_idle: got %b want 1", all_idle); end
    $display("reset transaction done");
  endtask

  task automatic test_single_burst();
    start_clean();
    load(2, 3);
    active = 1'b1;
    reset = 1'b0;
    settle();
    n_checks++;
    if ({busy, pop, all_idle} !== 6'b0) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b pop=%b all_idle=%b want 0 0000 0", busy, pop, all_idle);
    end
    tick();
    n_checks++;
    if ({busy, grant_idx, pop, push} !== {1'b1, 2'd2, 4'b0100, 1'b0}) begin
      n_fail++;
      $display("FAIL single_c1: busy=%b grant=%0d pop=%b push=%b want 1 2 0100 0", busy, grant_idx, pop, push);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      n_checks++;
      if ({pop, push, route_sel} !== {4'b0100, 1'b1, 2'd2}) begin
        n_fail++;
        $display("FAIL single_c%0d: pop=%b push=%b route=%0d want 0100 1 2", c, pop, push, route_sel);
      end
    end
    tick();
    n_checks++;
    if ({pop, push, route_sel} !== {4'b0000, 1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL single_c4: pop=%b push=%b route=%0d want 0000 1 2", pop, push, route_sel);
    end
    tick();
    n_checks++;
    if ({busy, push, all_idle} !== 3'b001) begin
      n_fail++;
      $display("FAIL single_c5: busy=%b push=%b all_idle=%b want 0 0 1", busy, push, all_idle);
    end
    $display("single burst input 2: 3 words");
  endtask

  task automatic test_round_robin();
    int base [4];
    start_clean();
    for (int i = 0; i < 4; i++) begin load(i, 10); base[i] = popped[i]; end
    active = 1'b1;
    reset = 1'b0;
    settle();
    for (int g = 0; g < 5; g++) begin
      logic [1:0] exp_g;
      logic [3:0] exp_pop;
      exp_g = 2'(g % 4);
      exp_pop = 4'b0001 << exp_g;
      n_checks++;
      if ({busy, pop} !== 5'b0) begin
        n_fail++;
        $display("FAIL rr_bubble%0d: busy=%b pop=%b want 0 0000", g, busy, pop);
      end
      if (g > 0) begin
        n_checks++;
        if ({push, route_sel} !== {1'b1, exp_g - 2'd1}) begin
          n_fail++;
          $display("FAIL rr_tail%0d: push=%b route=%0d want 1 %0d", g, push, route_sel, exp_g - 2'd1);
        end
      end
      tick();
      for (int b = 0; b < 4; b++) begin
        n_checks++;
        if ({grant_idx, pop} !== {exp_g, exp_pop}) begin
          n_fail++;
          $display("FAIL rr_g%0d_b%0d: grant=%0d pop=%b want %0d %b", g, b, grant_idx, pop, exp_g, exp_pop);
        end
        tick();
      end
      $display("grant %0d -> input %0d, 4 words", g, exp_g);
    end
    n_checks++;
    if ((popped[0] - base[0]) != 8 || (popped[1] - base[1]) != 4 ||
        (popped[2] - base[2]) != 4 || (popped[3] - base[3]) != 4) begin
      n_fail++;
      $display("FAIL rr_counts: got %0d %0d %0d %0d want 8 4 4 4", popped[0] - base[0],
               popped[1] - base[1], popped[2] - base[2], popped[3] - base[3]);
    end
  endtask

  task automatic test_alm_full();
    int base1;
    start_clean();
    load(1, 10);
    load(2, 10);
    base1 = popped[1];
    active = 1'b1;
    reset = 1'b0;
    settle();
    tick();
    tick();
    tick();
    alm_full_out = 4'b0010;
    settle();
    n_checks++;
    if ({pop, busy, push} !== {4'b0000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL af_same_cycle: pop=%b busy=%b push=%b want 0000 1 1", pop, busy, push);
    end
    n_checks++;
    if (popped[1] - base1 != 2) begin n_fail++; $display("FAIL af_count: got %0d want 2", popped[1] - base1); end
    tick();
    n_checks++;
    if ({busy, push, pop} !== 6'b0) begin
      n_fail++;
      $display("FAIL af_idle: busy=%b push=%b pop=%b want 0 0 0000", busy, push, pop);
    end
    tick();
    n_checks++;
    if ({grant_idx, pop} !== {2'd2, 4'b0100}) begin
      n_fail++;
      $display("FAIL af_next_grant: grant=%0d pop=%b want 2 0100", grant_idx, pop);
    end
    alm_full_out = 4'b0000;
    $display("alm_full stop on input 1 after 2 words");
  endtask

  task automatic test_active_drop();
    start_clean();
    load(0, 10);
    active = 1'b1;
    reset = 1'b0;
    settle();
    tick();
    tick();
    active = 1'b0;
    settle();
    n_checks++;
    if ({pop, push, route_sel} !== {4'b0000, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL act_drop: pop=%b push=%b route=%0d want 0000 1 0", pop, push, route_sel);
    end
    tick();
    n_checks++;
    if ({busy, push} !== 2'b00) begin n_fail++; $display("FAIL act_exit: busy=%b push=%b want 0 0", busy, push); end
    tick();
    tick();
    n_checks++;
    if ({busy, pop} !== 5'b0) begin n_fail++; $display("FAIL act_hold: busy=%b pop=%b want 0 0000", busy, pop); end
    active = 1'b1;
    tick();
    n_checks++;
    if ({busy, grant_idx, pop} !== {1'b1, 2'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL act_resume: busy=%b grant=%0d pop=%b want 1 0 0001", busy, grant_idx, pop);
    end
    $display("active drop after 1 word, resumed");
  endtask

  task automatic test_reset_mid_burst();
    start_clean();
    load(3, 10);
    active = 1'b1;
    reset = 1'b0;
    settle();
    tick();
    n_checks++;
    if ({grant_idx, pop} !== {2'd3, 4'b1000}) begin
      n_fail++;
      $display("FAIL rst_mid_grant: grant=%0d pop=%b want 3 1000", grant_idx, pop);
    end
    tick();
    reset = 1'b1;
    settle();
    n_checks++;
    if ({pop, push} !== {4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid_pop: pop=%b push=%b want 0000 1", pop, push);
    end
    tick();
    n_checks++;
    if ({push, busy, grant_idx} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: push=%b busy=%b grant=%0d want 0 0 0", push, busy, grant_idx);
    end
    load(0, 5);
    reset = 1'b0;
    tick();
    n_checks++;
    if ({grant_idx, pop} !== {2'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL rst_mid_regrant: grant=%0d pop=%b want 0 0001", grant_idx, pop);
    end
    $display("reset mid-burst, regrant to input 0");
  endtask

  task automatic test_priority();
    int base3;
    start_clean();
    load(0, 20);
    load(3, 20);
    base3 = popped[3];
    active = 1'b1;
    reset = 1'b0;
    settle();
    for (int g = 0; g < 4; g++) begin
      logic [1:0] exp_g;
`ifdef TL_SCHED_STRICT_PRIO_EN
      exp_g = 2'd0;
`else
      exp_g = (g % 2 == 1) ? 2'd3 : 2'd0;
`endif
      tick();
      n_checks++;
      if ({grant_idx, pop} !== {exp_g, 4'b0001 << exp_g}) begin
        n_fail++;
        $display("FAIL prio_g%0d: grant=%0d pop=%b want %0d", g, grant_idx, pop, exp_g);
      end
      tick();
      tick();
      tick();
      tick();
      $display("prio grant %0d -> input %0d", g, exp_g);
    end
    n_checks++;
`ifdef TL_SCHED_STRICT_PRIO_EN
    if (popped[3] - base3 != 0) begin n_fail++; $display("FAIL prio_in3: got %0d want 0", popped[3] - base3); end
`else
    if (popped[3] - base3 != 8) begin n_fail++; $display("FAIL prio_in3: got %0d want 8", popped[3] - base3); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_alm_full();
    test_active_drop();
    test_reset_mid_burst();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
